antirrebote: RTL

ANTIRREBOTE -- requirements
Module: antirrebote

---
 rtl/antirrebote.sv | 109 ++++++++++
 1 files changed

// File: rtl/antirrebote.sv
// Push-button debouncer: two-flop synchronizer followed by a four-state qualifier
// that emits a single-cycle EN pulse per accepted press and a debounced level.
module antirrebote #(
    parameter int DB_CYCLES = 100000,
    parameter int CW        = $clog2(DB_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic EN,
    output logic btn_db
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHK_HIGH = 2'd1,
        HELD     = 2'd2,
        CHK_LOW  = 2'd3
    } state_t;

    // Terminal count: the counter reaches this value on the last qualifying sample.
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    state_t        state_q, state_d;
    logic          ff1_q, ff1_d;
    logic          ff2_q, ff2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          en_q, en_d;
    logic          db_q, db_d;
    logic          btn_s;

    assign btn_s  = ff2_q;
    assign EN     = en_q;
    assign btn_db = db_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff1_q   <= 1'b0;
            ff2_q   <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            db_q    <= 1'b0;
        end else begin
            ff1_q   <= ff1_d;
            ff2_q   <= ff2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            db_q    <= db_d;
        end
    end

    always_comb begin
        ff1_d   = btn_in;
        ff2_d   = ff1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        en_d    = 1'b0;
        db_d    = db_q;

        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = CHK_HIGH;
                    cnt_d   = '0;
                end
            end
            CHK_HIGH: begin
                if (!btn_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    // Press accepted: pulse EN once and raise the debounced level.
                    state_d = HELD;
                    cnt_d   = '0;
                    en_d    = 1'b1;
                    db_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d = CHK_LOW;
                    cnt_d   = '0;
                end
            end
            CHK_LOW: begin
                if (btn_s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    // Release accepted: level drops, no EN pulse on this side.
                    state_d = IDLE;
                    cnt_d   = '0;
                    db_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule
